// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit add/subtract split into STAGES slices.
// Each slice is a two-level carry-lookahead adder (GROUP-bit groups, then a
// lookahead across groups). The carry between slices is registered, so slice k
// is added in pipeline stage k. Unconsumed operand bits are skewed forward and
// finished sum slices accumulate, so the last stage holds the aligned result.
// A single advance enable stalls the whole pipe under back-pressure.
module pipelined_cla_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int GROUP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int W_S = WIDTH / STAGES;
  localparam int NG  = W_S / GROUP;

  if ((STAGES < 1) || (STAGES > WIDTH) || (WIDTH % STAGES != 0) || (W_S % GROUP != 0)) begin : g_param_chk
    $error("pipelined_cla_adder: WIDTH must split into STAGES slices of whole GROUPs");
  end

  // Two-level lookahead slice adder: returns {carry_out, sum}.
  function automatic logic [W_S:0] cla_slice(input logic [W_S-1:0] x,
                                             input logic [W_S-1:0] y,
                                             input logic           cin);
    logic [W_S-1:0] g, p, c;
    logic [NG-1:0]  gg, gp;
    logic [NG:0]    gc;
    logic           term, acc;
    g = x & y;
    p = x ^ y;
    // Group generate/propagate
    for (int j = 0; j < NG; j++) begin
      acc = 1'b0;
      for (int u = 0; u < GROUP; u++) begin
        term = g[j*GROUP+u];
        for (int v = u + 1; v < GROUP; v++) term = term & p[j*GROUP+v];
        acc = acc | term;
      end
      gg[j] = acc;
      gp[j] = &p[j*GROUP +: GROUP];
    end
    // Group carries, each expanded directly from cin (no chaining)
    gc[0] = cin;
    for (int j = 0; j < NG; j++) begin
      acc = 1'b0;
      for (int m = 0; m <= j; m++) begin
        term = gg[m];
        for (int n = m + 1; n <= j; n++) term = term & gp[n];
        acc = acc | term;
      end
      term = cin;
      for (int n = 0; n <= j; n++) term = term & gp[n];
      gc[j+1] = acc | term;
    end
    // Bit carries inside each group, expanded from the group carry-in
    for (int j = 0; j < NG; j++) begin
      for (int t = 0; t < GROUP; t++) begin
        acc = gc[j];
        for (int v = 0; v < t; v++) acc = acc & p[j*GROUP+v];
        for (int u = 0; u < t; u++) begin
          term = g[j*GROUP+u];
          for (int v = u + 1; v < t; v++) term = term & p[j*GROUP+v];
          acc = acc | term;
        end
        c[j*GROUP+t] = acc;
      end
    end
    return {gc[NG], p ^ c};
  endfunction

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             ovf_d, ovf_q;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign cin_eff  = sub | c_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int REM = WIDTH - k * W_S;   // operand bits not yet consumed
    localparam int LO  = (k + 1) * W_S;     // sum bits finished after this stage

    logic [REM-1:0] a_in, b_in;
    logic           c_in_w, v_in;
    logic [W_S:0]   res;
    logic [LO-1:0]  s_d, s_q;
    logic           c_q, v_q;

    if (k == 0) begin : g_src
      assign a_in   = a;
      assign b_in   = b_eff;
      assign c_in_w = cin_eff;
      assign v_in   = in_valid;
      assign s_d    = res[W_S-1:0];
    end else begin : g_src
      assign a_in   = g_stg[k-1].g_fwd.a_q;
      assign b_in   = g_stg[k-1].g_fwd.b_q;
      assign c_in_w = g_stg[k-1].c_q;
      assign v_in   = g_stg[k-1].v_q;
      assign s_d    = {res[W_S-1:0], g_stg[k-1].s_q};
    end

    assign res = cla_slice(a_in[W_S-1:0], b_in[W_S-1:0], c_in_w);

    // Stage k register: accumulated sum, slice carry and slot valid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (adv) begin
        s_q <= s_d;
        c_q <= res[W_S];
        v_q <= v_in;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-W_S-1:0] a_q, b_q;
      // Skew the still-unused upper operand bits to the next stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[REM-1:W_S];
          b_q <= b_in[REM-1:W_S];
        end
      end
    end
  end

  // Carry into the MSB is recovered as a^b^sum at that bit
  assign ovf_d = g_stg[STAGES-1].a_in[W_S-1] ^ g_stg[STAGES-1].b_in[W_S-1] ^
                 g_stg[STAGES-1].res[W_S-1]  ^ g_stg[STAGES-1].res[W_S];

  // Overflow flag registered alongside the final stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (adv) ovf_q <= ovf_d;
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign sum       = g_stg[STAGES-1].s_q;
  assign c_out     = g_stg[STAGES-1].c_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder (WIDTH=64, STAGES=4, GROUP=4).
module tb_pipelined_cla_adder;
  localparam int WIDTH  = 64;
  localparam int STAGES = 4;
  localparam int GROUP  = 4;

  typedef logic [WIDTH+1:0] res_t;  // {overflow, c_out, sum}

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] a, b, sum;
  logic             c_in, sub, c_out, overflow;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   rnd_rdy = 1'b0;
  res_t exp_q[$];
  int   out_cyc[$];

  pipelined_cla_adder #(.WIDTH(WIDTH), .STAGES(STAGES), .GROUP(GROUP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic ci, input logic sb);
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   t;
    logic             ov;
    be = sb ? ~bv : bv;
    t  = {1'b0, av} + {1'b0, be} + {{WIDTH{1'b0}}, (sb ? 1'b1 : ci)};
    ov = (av[WIDTH-1] == be[WIDTH-1]) && (t[WIDTH-1] != av[WIDTH-1]);
    return {ov, t[WIDTH], t[WIDTH-1:0]};
  endfunction

  task automatic chk(input string tag, input res_t got, input res_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop on emitted results, push on accepted operands
  always @(negedge clk) begin
    res_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious out_valid", res_t'(1), res_t'(0));
        else begin
          e = exp_q.pop_front();
          chk("scoreboard", {overflow, c_out, sum}, e);
          out_cyc.push_back(cyc);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, c_in, sub));
    end
  end

  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic ci, input logic sb);
    a = av; b = bv; c_in = ci; sub = sb; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send timeout", res_t'(0), res_t'(1));
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain queue empty", res_t'(exp_q.size()), res_t'(0));
  endtask

  task automatic run_one(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic ci, input logic sb, input logic [WIDTH-1:0] es,
                         input logic ec, input logic eo);
    int t0;
    out_ready = 1'b1;
    t0 = cyc;
    send(av, bv, ci, sb);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk({tag, " valid"}, res_t'(out_valid), res_t'(1));
    chk({tag, " latency"}, res_t'(cyc - t0), res_t'(STAGES));
    chk({tag, " result"}, {overflow, c_out, sum}, {eo, ec, es});
    @(posedge clk); #1;
  endtask

  initial begin
    int t0;
    int n0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", res_t'(out_valid), res_t'(0));
    chk("reset outputs", {overflow, c_out, sum}, res_t'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", res_t'(in_ready), res_t'(1));
    @(posedge clk); #1;

    // Directed arithmetic cases
    run_one("add", 64'hFF, 64'h12, 1'b0, 1'b0, 64'h111, 1'b0, 1'b0);
    run_one("carry chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    run_one("pos overflow", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_one("sub borrow", 64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_one("sub no borrow", 64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0);
    run_one("add cin", 64'h0F, 64'h0F, 1'b1, 1'b0, 64'h1F, 1'b0, 1'b0);
    run_one("neg overflow", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Back-to-back streaming
    out_ready = 1'b1;
    out_cyc.delete();
    t0 = cyc;
    for (int i = 0; i < 8; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'(i % 2));
    chk("stream accept rate", res_t'(cyc - t0), res_t'(8));
    drain();
    chk("stream count", res_t'(out_cyc.size()), res_t'(8));
    if (out_cyc.size() == 8) begin
      chk("stream first latency", res_t'(out_cyc[0] - t0), res_t'(STAGES));
      for (int i = 1; i < 8; i++) chk("stream consecutive", res_t'(out_cyc[i] - out_cyc[i-1]), res_t'(1));
    end
    @(posedge clk); #1;

    // Back-pressure: fill, stall 5 cycles with a pending op, release, then bubbles
    out_cyc.delete();
    out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    a = 64'hDEAD_BEEF_0000_0001; b = 64'h1111_2222_3333_4444; c_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall in_ready", res_t'(in_ready), res_t'(0));
      chk("stall out_valid", res_t'(out_valid), res_t'(1));
      if (exp_q.size() != 0) chk("stall hold", {overflow, c_out, sum}, exp_q[0]);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    send(64'h1, 64'h2, 1'b0, 1'b0);
    idle(2);
    send(64'h10, 64'h20, 1'b1, 1'b0);
    idle(3);
    send(64'h100, 64'h1, 1'b0, 1'b1);
    drain();
    chk("backpressure count", res_t'(out_cyc.size()), res_t'(STAGES + 4));
    @(posedge clk); #1;

    // Random traffic with random back-pressure and bubbles
    out_cyc.delete();
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send((i % 7 == 0) ? '1 : {$urandom, $urandom}, {$urandom, $urandom},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 2)));
    end
    rnd_rdy = 1'b0;
    drain();
    chk("random count", res_t'(out_cyc.size()), res_t'(40));
    @(posedge clk); #1;

    // Asynchronous reset with three operations in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    @(posedge clk); #3;
    chk("pre-reset valid", res_t'(out_valid), res_t'(1));
    rst_n = 1'b0;
    #1;
    chk("async reset valid", res_t'(out_valid), res_t'(0));
    chk("async reset outputs", {overflow, c_out, sum}, res_t'(0));
    exp_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", res_t'(in_ready), res_t'(1));
    n0 = out_cyc.size();
    out_ready = 1'b1;
    @(posedge clk); #1;
    idle(10);
    chk("no stale results", res_t'(out_cyc.size() - n0), res_t'(0));
    run_one("after reset", 64'h1234, 64'h4321, 1'b0, 1'b0, 64'h5555, 1'b0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined successor to the team's 64-bit combinational carry-lookahead adder.
- Splits a WIDTH-bit add/subtract into STAGES slices. Each slice is a GROUP-bit lookahead adder, with a registered carry rippling slice-to-slice across pipeline stages.
- Valid/ready handshake on both sides; one result per cycle sustained.
- Sits in the 64-bit datapath wherever a clocked, back-pressurable adder is needed.

Parameters:
- WIDTH, 64, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth = number of slices; slice width W_S = WIDTH/STAGES; 1 <= STAGES <= WIDTH.
- GROUP, 4, lookahead group size inside a slice; W_S must be a multiple of GROUP.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c_in  in  1  carry-in (add mode only)
- sub  in  1  1 = compute a - b
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- c_out  out  1  carry-out (sub: 1 = no borrow)
- overflow  out  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: all stage valid bits = 0, out_valid = 0, sum = 0, c_out = 0, overflow = 0. All pipeline data registers clear.
- Reset mid-operation: in-flight operations are discarded. in_ready = 1 on the first cycle after rst_n deasserts.
- Operand preparation at capture:
  - b_eff = sub ? ~b : b
  - cin_eff = sub ? 1 : c_in; c_in is ignored when sub = 1.
- Slice processing:
  - Stage k (0..STAGES-1) adds slice k of a and b_eff, using the carry registered by stage k-1 (stage 0 uses cin_eff).
  - Each slice uses GROUP-bit generate/propagate lookahead, with a second lookahead level across groups. No bit-serial ripple inside a slice.
  - Unconsumed upper operand slices and already-computed lower sum slices are carried forward in stage registers (skew/deskew).
  - The final stage presents the full, aligned sum.
- Outputs:
  - c_out = carry out of bit WIDTH-1.
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, taken from the final stage.
- Latency: exactly STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid = 1, when unstalled. STAGES = 1 gives a registered adder with latency 1.
- Flow control:
  - Single global advance enable: adv = ~out_valid | out_ready, and in_ready = adv.
  - When adv = 0, every stage holds, including data and valid bits. sum, c_out and overflow stay stable while out_valid = 1 and out_ready = 0.
  - Bubbles (in_valid = 0 on an advancing cycle) propagate as valid = 0 slots. Empty slots never set out_valid.
  - Simultaneous accept and emit: when full with out_ready = 1 and in_valid = 1, the new operation enters and the oldest leaves in the same cycle. Throughput is 1 op/cycle with no gap.
  - Results emerge strictly in acceptance order.
- Arithmetic wraps modulo 2^WIDTH; no saturation.
- Elaboration error if WIDTH % STAGES != 0 or W_S % GROUP != 0.

Test Plan:
- Reset then single add: a = 0xFF, b = 0x12, c_in = 0, sub = 0 -> after 4 cycles, out_valid = 1, sum = 0x111, c_out = 0, overflow = 0.
- Full carry chain across all slices: a = 0xFFFF_FFFF_FFFF_FFFF, b = 0x1, c_in = 0 -> sum = 0, c_out = 1, overflow = 0.
- Signed overflow and subtract:
  - a = 0x7FFF_FFFF_FFFF_FFFF, b = 1 (add) -> sum = 0x8000_0000_0000_0000, overflow = 1, c_out = 0.
  - Then sub with a = 5, b = 7, c_in = 1 -> sum = 0xFFFF_FFFF_FFFF_FFFE, c_out = 0, overflow = 0.
- Back-to-back streaming: 8 consecutive ops with out_ready held at 1 -> 8 results on 8 consecutive cycles in order, starting 4 cycles after the first accept.
- Back-pressure: fill the pipe, then hold out_ready = 0 for 5 cycles -> in_ready = 0, sum stable; releasing out_ready drains the pipe in order with no loss or duplication. Bubbles inserted via in_valid = 0 never produce out_valid.
- Async reset mid-stream: assert rst_n = 0 between clock edges with 3 ops in flight -> outputs clear immediately with no clock edge; after release, none of the 3 results ever appear.
